// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage: single-outstanding imem requests buffered in a PC-tagged FIFO
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       instr_valid,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISC} state_t;

    state_t         state;
    logic [31:0]    fpc;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [31:0]    mem_instr [DEPTH];
    logic [31:0]    mem_pc    [DEPTH];
    logic           push;
    logic           pop;
    logic [CW-1:0]  count_nxt;

    assign imem_req    = (state == REQ);
    assign imem_addr   = fpc;
    assign instr_valid = (count != '0);
    assign instr       = mem_instr[rd_ptr];
    assign instr_pc    = mem_pc[rd_ptr];

    // A redirect kills both the pop and any response landing in the same cycle
    assign pop  = instr_valid && instr_ready && !redirect;
    assign push = (state == WAIT) && imem_ack && !redirect;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= fpc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            fpc    <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
            fpc    <= redirect_pc & ~32'h3;
            // An outstanding request must be drained in DISC before refetching
            case (state)
                IDLE:    state <= REQ;
                REQ:     state <= DISC;
                WAIT:    state <= imem_ack ? REQ : DISC;
                DISC:    state <= imem_ack ? REQ : DISC;
                default: state <= IDLE;
            endcase
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                fpc    <= fpc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case (state)
                IDLE: begin
                    if (count < FULL)
                        state <= REQ;
                end
                REQ:  state <= WAIT;
                WAIT: begin
                    if (imem_ack)
                        state <= (count_nxt < FULL) ? REQ : IDLE;
                end
                DISC: begin
                    if (imem_ack)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle decode/execute datapath.
- Issues word reads to a variable-latency instruction memory and buffers the returned words with their PCs in a small FIFO.
- Presents the next instruction to the core through a valid/ready handshake.
- Accepts a redirect (taken branch, jal, jalr) from the core; the redirect flushes the FIFO and squashes any in-flight fetch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- imem_req  out  1  one-cycle fetch request strobe
- imem_addr  out  32  word address of request; valid when imem_req=1
- imem_ack  in  1  one-cycle response strobe; at least 1 cycle after imem_req; responses return in order
- imem_rdata  in  32  instruction word; valid when imem_ack=1
- redirect  in  1  one-cycle redirect strobe from the core
- redirect_pc  in  32  new fetch address
- instr_valid  out  1  FIFO head valid
- instr  out  32  head instruction
- instr_pc  out  32  PC of head instruction
- instr_ready  in  1  core consumes head this cycle
- count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst=1 at an edge):
  - count=0, instr_valid=0, imem_req=0, fetch pointer fpc=RESET_PC, state=IDLE.
  - FIFO contents are don't-care. instr and instr_pc are don't-care while instr_valid=0.
  - Reset overrides everything, including mid-request. Any ack for a pre-reset request is the memory model's responsibility and is not generated by the bench.
- FIFO:
  - Register storage with rd_ptr and wr_ptr that wrap modulo DEPTH.
  - instr and instr_pc read combinationally from the head entry.
  - instr_valid = (count != 0).
  - Pop occurs when instr_valid && instr_ready. instr_ready while empty has no effect.
  - A push and pop in the same cycle leave count unchanged.
- Fetch FSM: at most one outstanding request. imem_req=1 only in REQ, with imem_addr=fpc.
  - IDLE: count<DEPTH -> REQ; else stay.
  - REQ: -> WAIT unconditionally. imem_ack during REQ is illegal.
  - WAIT, on imem_ack:
    - Push {imem_rdata, fpc}; fpc += 4 (wraps at 2^32).
    - -> REQ if the post-push/pop count < DEPTH; else -> IDLE.
  - WAIT, no ack: stay.
  - DISC: imem_ack -> discard data, -> REQ; else stay.
- Overflow protection: a request is only issued when count<DEPTH, and count cannot grow while a request is outstanding, so a push never meets a full FIFO.
- Redirect (highest priority, any state):
  - Same edge: flush (count=0, rd_ptr=wr_ptr), fpc = redirect_pc & ~32'h3. Any pop that cycle is ignored.
  - Next state depends on current state:
    - REQ -> DISC.
    - WAIT without ack -> DISC.
    - WAIT with ack in the same cycle -> the ack data is dropped; -> REQ.
    - IDLE -> REQ.
    - DISC without ack -> DISC.
    - DISC with ack in the same cycle -> REQ.
  - instr_valid is 0 in the cycle after redirect.
- Latency and throughput:
  - First imem_req is asserted in the cycle after rst deasserts.
  - With a 1-cycle memory, each instruction costs 2 cycles (REQ, WAIT).
  - instr_valid rises the cycle after the ack.

Test Plan:
- Reset/cold start (RESET_PC=0, 1-cycle memory, rdata=addr|0x13, ready=1):
  - imem_req in cycle 1 with addr 0x0.
  - instr_valid in cycle 3 with instr=0x13, instr_pc=0x0.
  - Next heads are pc 0x4 and 0x8, one every 2 cycles.
- Fill/full (ready=0, DEPTH=4):
  - Exactly 4 requests are issued, for addresses 0x0, 0x4, 0x8, 0xC.
  - count reaches 4, FSM idles, and no 5th imem_req appears.
  - Raising ready for one cycle pops pc 0x0, then one new request for 0x10 is issued.
- Simultaneous push and pop (count=2, ack in WAIT, ready=1):
  - count stays 2.
  - Head advances to the next PC.
  - FSM goes to REQ.
- Redirect during outstanding request (3-cycle memory latency, redirect in WAIT, redirect_pc=0x103):
  - FIFO is flushed; count=0 next cycle.
  - The stale ack is discarded.
  - The next imem_req has addr 0x100, and the first new head has instr_pc=0x100.
- Redirect with coincident ack and pop (count=1, ack, ready and redirect to 0x200 in the same cycle):
  - count=0 and no push occurs.
  - Next imem_req has addr 0x200.
- Pointer wrap and reset mid-operation:
  - Stream 10 instructions with ready toggling; PCs arrive in order 0x0 through 0x24 with no loss or duplication.
  - Asserting rst in WAIT gives count=0, instr_valid=0, and a refetch from RESET_PC.
